b12_player: RTL and testbench

Automatic opponent for the b12 color-sequence game. It pulses the game's `start`, watches the `nl` LEDs while the game demonstrates each round, stores the sequence, and replays it on the `k` keys. It sits beside b12 in the bench and regression harness. It drives b12's `start`/`k` inputs and consumes b12's `nl`/`nloss` outputs, so the game runs to completion without a human.

---
 rtl/b12_player.sv | 229 ++++++++++++++++++++++
 tb/tb_b12_player.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/b12_player.sv
// b12_player: automatic opponent for the b12 color-sequence game.
// Ports: clock/reset(async low); go, blunder; nl, nloss from game;
//   start, k to game; busy, won, lost, fault, seq_err, round status.
module b12_player #(
   parameter int SIZE_ADDRESS = 5,
   parameter int COD_COLOR    = 2,
   parameter int WDOG_MAX     = 200
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  go,
   input  logic                  blunder,
   input  logic [3:0]            nl,
   input  logic                  nloss,
   output logic                  start,
   output logic [3:0]            k,
   output logic                  busy,
   output logic                  won,
   output logic                  lost,
   output logic                  fault,
   output logic                  seq_err,
   output logic [SIZE_ADDRESS:0] round
);

   localparam int DEPTH = 2 ** SIZE_ADDRESS;
   localparam logic [SIZE_ADDRESS:0] LEN_MAX =
      (SIZE_ADDRESS + 1)'(DEPTH);
   localparam logic [7:0] WD_LAST = 8'(WDOG_MAX - 1);

   typedef enum logic [3:0] {
      IDLE,
      START,
      WATCH_ON,
      WATCH_OFF,
      PRESS,
      ECHO_OFF,
      WON,
      LOST,
      FAULT
   } state_t;

   state_t state, state_n;

   logic [COD_COLOR-1:0]    mem [DEPTH];
   logic [SIZE_ADDRESS:0]   len, len_n;
   logic [SIZE_ADDRESS:0]   round_n;
   logic [SIZE_ADDRESS-1:0] idx, idx_n;
   logic [7:0]              wd, wd_n;

   logic       start_n, busy_n;
   logic       won_n, lost_n, fault_n, seq_err_n;
   logic [3:0] k_n;

   logic                 we;
   logic [COD_COLOR-1:0] color;
   logic [COD_COLOR-1:0] key_c;
   logic                 one_hot;
   logic                 last;
   logic                 watching;

   always_comb begin
      color = '0;
      case (nl)
         4'b0001: color = COD_COLOR'(0);
         4'b0010: color = COD_COLOR'(1);
         4'b0100: color = COD_COLOR'(2);
         4'b1000: color = COD_COLOR'(3);
         default: color = '0;
      endcase
   end

   assign one_hot  = (nl != 4'b0) && ((nl & (nl - 4'd1)) == 4'b0);
   assign last     = ({1'b0, idx} == len - 1'b1);
   assign watching = state inside {WATCH_ON, WATCH_OFF, PRESS, ECHO_OFF};

   // Key color for the press being entered; a blunder shifts it by one.
   assign key_c = mem[idx_n] + COD_COLOR'(blunder);

   always_comb begin
      state_n   = state;
      len_n     = len;
      idx_n     = idx;
      round_n   = round;
      start_n   = 1'b0;
      busy_n    = busy;
      won_n     = won;
      lost_n    = lost;
      fault_n   = fault;
      seq_err_n = seq_err;
      k_n       = k;
      we        = 1'b0;
      wd_n      = '0;

      // START is excluded: the game may still show the previous loss
      // until it has seen the start pulse.
      if (watching && nloss) begin
         state_n = LOST;
      end else if (watching && wd == WD_LAST) begin
         state_n = FAULT;
      end else begin
         unique case (state)
            IDLE, WON, LOST, FAULT: begin
               if (go) begin
                  won_n     = 1'b0;
                  lost_n    = 1'b0;
                  fault_n   = 1'b0;
                  seq_err_n = 1'b0;
                  round_n   = '0;
                  len_n     = (SIZE_ADDRESS + 1)'(1);
                  idx_n     = '0;
                  start_n   = 1'b1;
                  busy_n    = 1'b1;
                  state_n   = START;
               end
            end
            START: state_n = WATCH_ON;
            WATCH_ON: begin
               if (one_hot) begin
                  if (!last && mem[idx] != color)
                     seq_err_n = 1'b1;
                  we      = 1'b1;
                  state_n = WATCH_OFF;
               end else if (nl != 4'b0) begin
                  state_n = FAULT;
               end
            end
            WATCH_OFF: begin
               if (nl == 4'b0) begin
                  if (last) begin
                     idx_n   = '0;
                     state_n = PRESS;
                  end else begin
                     idx_n   = idx + 1'b1;
                     state_n = WATCH_ON;
                  end
               end
            end
            PRESS: begin
               if (nl != 4'b0) begin
                  if (nl != k) begin
                     state_n = FAULT;
                  end else begin
                     k_n     = 4'b0;
                     state_n = ECHO_OFF;
                  end
               end
            end
            ECHO_OFF: begin
               if (nl == 4'b0) begin
                  if (!last) begin
                     idx_n   = idx + 1'b1;
                     state_n = PRESS;
                  end else begin
                     round_n = round + 1'b1;
                     idx_n   = '0;
                     if (len == LEN_MAX) begin
                        state_n = WON;
                     end else begin
                        len_n   = len + 1'b1;
                        state_n = WATCH_ON;
                     end
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end

      if (state_n != state) begin
         unique case (state_n)
            PRESS: k_n = 4'b0001 << key_c;
            WON: begin
               won_n  = 1'b1;
               busy_n = 1'b0;
               k_n    = 4'b0;
            end
            LOST: begin
               lost_n = 1'b1;
               busy_n = 1'b0;
               k_n    = 4'b0;
            end
            FAULT: begin
               fault_n = 1'b1;
               busy_n  = 1'b0;
               k_n     = 4'b0;
            end
            default: ;
         endcase
      end else if (watching) begin
         wd_n = wd + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         len     <= '0;
         idx     <= '0;
         wd      <= '0;
         start   <= 1'b0;
         k       <= 4'b0;
         busy    <= 1'b0;
         won     <= 1'b0;
         lost    <= 1'b0;
         fault   <= 1'b0;
         seq_err <= 1'b0;
         round   <= '0;
      end else begin
         state   <= state_n;
         len     <= len_n;
         idx     <= idx_n;
         wd      <= wd_n;
         start   <= start_n;
         k       <= k_n;
         busy    <= busy_n;
         won     <= won_n;
         lost    <= lost_n;
         fault   <= fault_n;
         seq_err <= seq_err_n;
         round   <= round_n;
      end
   end

   always_ff @(posedge clock) begin
      if (we)
         mem[idx] <= color;
   end

endmodule

// File: tb/tb_b12_player.sv
// tb_b12_player: randomized game model driving b12_player.
// Ports: none; drives clock/reset and plays b12 behaviourally.
module tb_b12_player;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       go = 1'b0;
   logic       blunder = 1'b0;
   logic [3:0] nl = 4'b0;
   logic       nloss = 1'b0;
   logic       start;
   logic [3:0] k;
   logic       busy, won, lost, fault, seq_err;
   logic [5:0] round;

   int checks = 0;
   int errors = 0;

   logic [1:0] seq [32];

   b12_player dut (
      .clock   (clock),
      .reset   (reset),
      .go      (go),
      .blunder (blunder),
      .nl      (nl),
      .nloss   (nloss),
      .start   (start),
      .k       (k),
      .busy    (busy),
      .won     (won),
      .lost    (lost),
      .fault   (fault),
      .seq_err (seq_err),
      .round   (round)
   );

   always #5 clock = ~clock;

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] oh(input int c);
      return 4'b0001 << (c % 4);
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic new_seq;
      for (int i = 0; i < 32; i++)
         seq[i] = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_k;
      int n = 0;
      while (k == 4'b0 && n < 20) begin
         tick;
         n++;
      end
   endtask

   // go pulse; start must be high for exactly one cycle
   task automatic do_go;
      go = 1'b1;
      tick;
      go = 1'b0;
      chk("start_rise", 32'(start), 32'd1);
      chk("busy_go", 32'(busy), 32'd1);
      tick;
      chk("start_fall", 32'(start), 32'd0);
   endtask

   // game demonstrates the first r items of its sequence
   task automatic demo(input int r);
      for (int i = 0; i < r; i++) begin
         nl = oh(int'(seq[i]));
         repeat ($urandom_range(1, 3)) tick;
         nl = 4'b0;
         repeat ($urandom_range(1, 3)) tick;
      end
   endtask

   // game waits for a key, echoes it, or flags a loss on a wrong key
   task automatic press(input int i, input bit bl, output bit ok);
      logic [3:0] exp;
      wait_k;
      blunder = 1'b0;
      exp = bl ? oh(int'(seq[i]) + 1) : oh(int'(seq[i]));
      chk("k_press", 32'(k), 32'(exp));
      tick;
      chk("k_hold", 32'(k), 32'(exp));
      if (k != oh(int'(seq[i]))) begin
         nloss = 1'b1;
         ok = 1'b0;
         tick;
         return;
      end
      nl = k;
      tick;
      chk("k_release", 32'(k), 32'd0);
      repeat ($urandom_range(0, 2)) tick;
      nl = 4'b0;
      ok = 1'b1;
   endtask

   task automatic play(input int rounds, input int bl_round,
                       output bit lostg);
      bit ok;
      lostg = 1'b0;
      for (int r = 1; r <= rounds; r++) begin
         blunder = (r == bl_round);
         demo(r);
         for (int i = 0; i < r; i++) begin
            press(i, (r == bl_round) && (i == 0), ok);
            if (!ok) begin
               lostg = 1'b1;
               return;
            end
         end
         tick;
         chk("round", 32'(round), 32'(r));
      end
   endtask

   initial begin
      bit lg;
      bit ok;

      // reset state
      repeat (3) tick;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_k", 32'(k), 32'd0);
      chk("rst_flags", 32'({won, lost, fault, seq_err}), 32'd0);
      chk("rst_round", 32'(round), 32'd0);
      reset = 1'b1;
      tick;

      // async reset in the middle of a press
      new_seq;
      seq[0] = 2'd2;
      do_go;
      demo(1);
      wait_k;
      chk("mid_k", 32'(k), 32'h4);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_k", 32'(k), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_round", 32'(round), 32'd0);
      chk("mid_rst_start", 32'(start), 32'd0);
      tick;
      reset = 1'b1;
      tick;

      // blunder at the first press of round 3
      new_seq;
      seq[0] = 2'd2;
      do_go;
      play(3, 3, lg);
      chk("bl_lossflag", 32'(lg), 32'd1);
      chk("bl_lost", 32'(lost), 32'd1);
      chk("bl_busy", 32'(busy), 32'd0);
      chk("bl_k", 32'(k), 32'd0);
      chk("bl_round", 32'(round), 32'd2);
      chk("bl_fault", 32'(fault), 32'd0);
      nloss = 1'b0;
      tick;

      // full game
      new_seq;
      do_go;
      chk("go_clr_lost", 32'(lost), 32'd0);
      play(32, 0, lg);
      chk("full_noloss", 32'(lg), 32'd0);
      chk("full_won", 32'(won), 32'd1);
      chk("full_round", 32'(round), 32'd32);
      chk("full_fault", 32'(fault), 32'd0);
      chk("full_seqerr", 32'(seq_err), 32'd0);
      chk("full_busy", 32'(busy), 32'd0);
      tick;

      // not one-hot LED pattern while watching
      do_go;
      nl = 4'b0011;
      tick;
      chk("oh_fault", 32'(fault), 32'd1);
      chk("oh_busy", 32'(busy), 32'd0);
      chk("oh_k", 32'(k), 32'd0);
      nl = 4'b0;
      tick;

      // watchdog boundary in WATCH_ON
      do_go;
      chk("wd_clr_fault", 32'(fault), 32'd0);
      repeat (199) tick;
      chk("wd_early", 32'(fault), 32'd0);
      chk("wd_early_busy", 32'(busy), 32'd1);
      tick;
      chk("wd_fault", 32'(fault), 32'd1);
      chk("wd_k", 32'(k), 32'd0);
      chk("wd_busy", 32'(busy), 32'd0);

      // round 2 demo changes item 0 from 1 to 3
      new_seq;
      seq[0] = 2'd1;
      do_go;
      demo(1);
      press(0, 1'b0, ok);
      tick;
      chk("se_round1", 32'(round), 32'd1);
      chk("se_clean", 32'(seq_err), 32'd0);
      seq[0] = 2'd3;
      demo(2);
      chk("se_flag", 32'(seq_err), 32'd1);
      press(0, 1'b0, ok);
      press(1, 1'b0, ok);
      tick;
      chk("se_round2", 32'(round), 32'd2);
      nloss = 1'b1;
      tick;
      chk("se_lost", 32'(lost), 32'd1);
      chk("se_sticky", 32'(seq_err), 32'd1);
      nloss = 1'b0;
      tick;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
